// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding and
// the opcode patterns that steer the fetch sequence.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_IMM    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [1:0] IMM_PREFIX = 2'b01;
  localparam logic [5:0] HLT_OPCODE = 6'b111111;

  function automatic logic is_imm_prefix(input logic [15:0] word);
    return word[15:14] == IMM_PREFIX;
  endfunction

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:10] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Program-counter register with synchronous reset value and load enable.
module pc_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [PC_W-1:0] pc_d,
  output logic [PC_W-1:0] pc_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks imem, pairs prefixed instructions with
// their immediate word, and feeds the IF/ID register.
//
//   state     | meaning
//   ST_FETCH  | fetching an instruction word at pc
//   ST_IMM    | prefix word saved, fetching its immediate at pc
//   ST_HALTED | HLT issued; pc frozen until a branch or reset
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic [15:0]     imem_word,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ifid_instr,
  output logic [15:0]     ifid_imm,
  output logic            ifid_valid,
  output logic            ifid_has_imm,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [15:0]     saved_q, saved_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     imm_q, imm_d;
  logic            valid_q, valid_d;
  logic            has_imm_q, has_imm_d;
  logic            halted_q, halted_d;
  logic            pc_load;
  logic [PC_W-1:0] pc_d;

  pc_reg #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load_en(pc_load),
    .pc_d   (pc_d),
    .pc_q   (pc)
  );

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    valid_d   = valid_q;
    has_imm_d = has_imm_q;
    pc_load   = 1'b0;
    pc_d      = pc + PC_W'(1);

    if (branch_taken) begin
      pc_load   = 1'b1;
      pc_d      = branch_target;
      state_d   = ST_FETCH;
      saved_d   = '0;
      valid_d   = 1'b0;
      has_imm_d = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        ST_FETCH: begin
          if (is_imm_prefix(imem_word)) begin
            // Prefix alone is not issuable; emit a bubble until the immediate arrives.
            saved_d   = imem_word;
            pc_load   = 1'b1;
            valid_d   = 1'b0;
            has_imm_d = 1'b0;
            state_d   = ST_IMM;
          end else if (is_hlt(imem_word)) begin
            instr_d   = imem_word;
            valid_d   = 1'b1;
            has_imm_d = 1'b0;
            state_d   = ST_HALTED;
          end else begin
            instr_d   = imem_word;
            valid_d   = 1'b1;
            has_imm_d = 1'b0;
            pc_load   = 1'b1;
          end
        end
        ST_IMM: begin
          instr_d   = saved_q;
          imm_d     = imem_word;
          valid_d   = 1'b1;
          has_imm_d = 1'b1;
          pc_load   = 1'b1;
          saved_d   = '0;
          state_d   = ST_FETCH;
        end
        ST_HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_FETCH;
          valid_d = 1'b0;
        end
      endcase
    end

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      saved_q   <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      valid_q   <= 1'b0;
      has_imm_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      has_imm_q <= has_imm_d;
      halted_q  <= halted_d;
    end
  end

  assign ifid_instr   = instr_q;
  assign ifid_imm     = imm_q;
  assign ifid_valid   = valid_q;
  assign ifid_has_imm = has_imm_q;
  assign halted       = halted_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port stall  input  1  hazard freeze; hold all state.
REQ-006 SHALL have port branch_taken  input  1  redirect request from later stage.
REQ-007 SHALL have port branch_target  input  PC_W  redirect destination word address.
REQ-008 SHALL have port imem_word  input  16  instruction-memory word at pc, combinational read.
REQ-009 SHALL have port pc  output  PC_W  current fetch word address.
REQ-010 SHALL have port ifid_instr  output  16  instruction word to IF/ID.
REQ-011 SHALL have port ifid_imm  output  16  immediate word, valid when ifid_has_imm=1.
REQ-012 SHALL have port ifid_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-013 SHALL have port ifid_has_imm  output  1  current IF/ID instruction carries an immediate.
REQ-014 SHALL have port halted  output  1  high while in HALTED state.

Function
REQ-015 SHALL implement FSM states FETCH, IMM, HALTED; priority rst > branch_taken > stall > advance.
REQ-016 FETCH, advance, imem_word[15:14]==2'b01: SHALL save word internally, pc<=pc+1, ifid_valid<=0, go IMM.
REQ-017 FETCH, advance, imem_word[15:10]==6'b111111 (HLT): SHALL set ifid_instr<=word, ifid_valid<=1, ifid_has_imm<=0, keep pc unchanged, go HALTED.
REQ-018 FETCH, advance, other word: SHALL set ifid_instr<=word, ifid_valid<=1, ifid_has_imm<=0, pc<=pc+1, stay FETCH.
REQ-019 IMM, advance: SHALL set ifid_instr<=saved word, ifid_imm<=imem_word, ifid_valid<=1, ifid_has_imm<=1, pc<=pc+1, go FETCH.
REQ-020 HALTED: SHALL hold pc, drive ifid_valid<=0; exit only via branch_taken or rst.
REQ-021 branch_taken in any state: SHALL set pc<=branch_target, ifid_valid<=0, ifid_has_imm<=0, discard any saved word, go FETCH, regardless of stall.
REQ-022 stall=1 without branch_taken: SHALL hold pc, state, saved word and all ifid_* outputs unchanged.
REQ-023 pc increment SHALL be modulo 2^PC_W (all-ones wraps to 0).
REQ-024 ifid_imm SHALL hold its last value when ifid_has_imm=0.
REQ-025 Latency: a word present on imem_word at edge N SHALL appear on ifid_* after edge N (one cycle).
REQ-026 halted SHALL be a registered decode of state==HALTED.

Reset
REQ-027 rst=1 at a clock edge SHALL set pc=RESET_PC, state=FETCH, ifid_instr=0, ifid_imm=0, ifid_valid=0, ifid_has_imm=0, halted=0, saved word=0.
REQ-028 rst SHALL override branch_taken and stall, including mid-IMM (saved word discarded).

Structure
REQ-029 Shared package fetch_pkg SHALL hold state encoding, IMM_PREFIX=2'b01, HLT_OPCODE=6'b111111.
REQ-030 PC storage SHALL be a sub-module pc_reg (PC_W-wide, synchronous reset to RESET_PC, load enable, data in).
REQ-031 No other sub-modules; FSM and IF/ID output registers SHALL reside in fetch_ctrl.

Verification
REQ-032 Reset then words 0x0C10, 0x1010 at pc 0,1, no stall -> ifid_instr 0x0C10 then 0x1010, valid 1, pc 1 then 2.
REQ-033 Word 0x4470 at pc 0, word 0x00AB at pc 1 -> cycle 1 valid 0; cycle 2 ifid_instr 0x4470, ifid_imm 0x00AB, has_imm 1, pc 2.
REQ-034 stall=1 for 3 cycles at pc 5 -> pc stays 5, ifid_* unchanged; release -> fetch resumes at 5.
REQ-035 In IMM with stall=1, branch_taken=1, branch_target 0x20 -> next cycle pc 0x20, valid 0, state FETCH, saved word dropped.
REQ-036 HLT (0xFC00) at pc 7 -> one valid cycle with 0xFC00, then halted=1, pc 7, valid 0 until branch_taken to 0x10 -> halted 0, pc 0x10.
REQ-037 PC_W=4, pc 0xF, normal word -> pc wraps to 0x0.
